// File: rtl/design_select_pkg.sv
// Shared types and constants for the design-select sequencer.
package design_select_pkg;

  localparam int unsigned DESIGN_IDX_W = 4;
  localparam logic [DESIGN_IDX_W-1:0] DESIGN_NONE = DESIGN_IDX_W'(0);

  // Sequencer states: deselect/settle, apply-with-reset, then run.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DESELECT = 2'd1,
    APPLY    = 2'd2,
    RUN      = 2'd3
  } dsel_state_e;

endpackage

// File: rtl/dsel_down_counter.sv
// Loadable down-counter with zero flag, shared by the settle and reset-hold phases.
module dsel_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/design_select_sequencer.sv
// Design-select sequencer: safely switches the design_select bus through
// deselect/settle and reset-hold phases before reporting the design active.
// Optional watchdog in RUN enabled by defining DSEL_WATCHDOG_EN.
module design_select_sequencer
  import design_select_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS     = 12,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned RST_HOLD_CYCLES = 8
`ifdef DSEL_WATCHDOG_EN
  ,
  parameter int unsigned WDT_CYCLES      = 1_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    req_valid,
  input  logic [DESIGN_IDX_W-1:0] req_design,
  output logic                    req_ready,
  output logic [DESIGN_IDX_W-1:0] design_select,
  output logic                    design_rst_hold,
  output logic                    gpio_hold,
  output logic                    active,
`ifdef DSEL_WATCHDOG_EN
  input  logic                    wdt_kick,
  output logic                    wdt_fired,
`endif
  output logic                    req_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > RST_HOLD_CYCLES) ? SETTLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD_CYCLES - 1);
`ifdef DSEL_WATCHDOG_EN
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
`endif

  dsel_state_e             r_state, w_state_nxt;
  logic [DESIGN_IDX_W-1:0] r_pending, w_pending_nxt;
  logic [DESIGN_IDX_W-1:0] r_sel, w_sel_nxt;
  logic                    r_rst_hold, w_rst_hold_nxt;
  logic                    r_gpio_hold, w_gpio_hold_nxt;
  logic                    r_active, w_active_nxt;
  logic                    r_req_err, w_req_err_nxt;
  logic                    r_req_ready, w_req_ready_nxt;
  logic                    w_xfer;
  logic                    w_out_of_range;
  logic [DESIGN_IDX_W-1:0] w_req_idx;
  logic                    w_cnt_load;
  logic [CNT_W-1:0]        w_cnt_val;
  logic                    w_cnt_dec;
  logic                    w_cnt_zero;
`ifdef DSEL_WATCHDOG_EN
  logic [WDT_W-1:0]        r_wdt, w_wdt_nxt;
  logic                    r_wdt_fired, w_wdt_fired_nxt;
`endif

  assign w_xfer         = req_valid && r_req_ready;
  assign w_out_of_range = (32'(req_design) > NUM_DESIGNS);
  assign w_req_idx      = w_out_of_range ? DESIGN_NONE : req_design;

  // Shared phase counter for settle and reset-hold windows.
  dsel_down_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_pending   <= DESIGN_NONE;
      r_sel       <= DESIGN_NONE;
      r_rst_hold  <= 1'b0;
      r_gpio_hold <= 1'b0;
      r_active    <= 1'b0;
      r_req_err   <= 1'b0;
      r_req_ready <= 1'b1;
`ifdef DSEL_WATCHDOG_EN
      r_wdt       <= '0;
      r_wdt_fired <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_sel       <= w_sel_nxt;
      r_rst_hold  <= w_rst_hold_nxt;
      r_gpio_hold <= w_gpio_hold_nxt;
      r_active    <= w_active_nxt;
      r_req_err   <= w_req_err_nxt;
      r_req_ready <= w_req_ready_nxt;
`ifdef DSEL_WATCHDOG_EN
      r_wdt       <= w_wdt_nxt;
      r_wdt_fired <= w_wdt_fired_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_sel_nxt       = r_sel;
    w_rst_hold_nxt  = r_rst_hold;
    w_gpio_hold_nxt = r_gpio_hold;
    w_active_nxt    = r_active;
    w_req_err_nxt   = r_req_err | (w_xfer & w_out_of_range);
    w_cnt_load      = 1'b0;
    w_cnt_val       = '0;
    w_cnt_dec       = 1'b0;
`ifdef DSEL_WATCHDOG_EN
    w_wdt_nxt       = '0;
    w_wdt_fired_nxt = r_wdt_fired;
`endif

    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_pending_nxt = w_req_idx;
          if (w_req_idx != DESIGN_NONE) begin
            w_state_nxt     = DESELECT;
            w_sel_nxt       = DESIGN_NONE;
            w_gpio_hold_nxt = 1'b1;
            w_active_nxt    = 1'b0;
            w_cnt_load      = 1'b1;
            w_cnt_val       = SETTLE_LOAD;
          end
        end
      end

      RUN: begin
        if (w_xfer) begin
          // Any request, including the current index, restarts the sequence.
          w_pending_nxt   = w_req_idx;
          w_state_nxt     = DESELECT;
          w_sel_nxt       = DESIGN_NONE;
          w_gpio_hold_nxt = 1'b1;
          w_active_nxt    = 1'b0;
          w_cnt_load      = 1'b1;
          w_cnt_val       = SETTLE_LOAD;
        end
`ifdef DSEL_WATCHDOG_EN
        else if (wdt_kick) begin
          w_wdt_nxt = '0;
        end else if (r_wdt == WDT_LAST) begin
          w_pending_nxt   = DESIGN_NONE;
          w_state_nxt     = DESELECT;
          w_sel_nxt       = DESIGN_NONE;
          w_gpio_hold_nxt = 1'b1;
          w_active_nxt    = 1'b0;
          w_cnt_load      = 1'b1;
          w_cnt_val       = SETTLE_LOAD;
          w_wdt_fired_nxt = 1'b1;
        end else begin
          w_wdt_nxt = r_wdt + WDT_W'(1);
        end
`endif
      end

      DESELECT: begin
        if (w_cnt_zero) begin
          if (r_pending != DESIGN_NONE) begin
            w_state_nxt     = APPLY;
            w_sel_nxt       = r_pending;
            w_rst_hold_nxt  = 1'b1;
            w_gpio_hold_nxt = 1'b1;
            w_cnt_load      = 1'b1;
            w_cnt_val       = HOLD_LOAD;
          end else begin
            w_state_nxt     = IDLE;
            w_gpio_hold_nxt = 1'b0;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      APPLY: begin
        if (w_cnt_zero) begin
          w_state_nxt     = RUN;
          w_rst_hold_nxt  = 1'b0;
          w_gpio_hold_nxt = 1'b0;
          w_active_nxt    = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == RUN);
  end

  assign req_ready       = r_req_ready;
  assign design_select   = r_sel;
  assign design_rst_hold = r_rst_hold;
  assign gpio_hold       = r_gpio_hold;
  assign active          = r_active;
  assign req_err         = r_req_err;
`ifdef DSEL_WATCHDOG_EN
  assign wdt_fired       = r_wdt_fired;
`endif

endmodule
